// File: rtl/user_mem_arb_pkg.sv
// Shared types and defaults for the user-area SRAM arbiter: FSM state encoding,
// requester indices and the default address window.
package user_mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC_WB = 3'd1,
        ACC_LA = 3'd2,
        RSP_WB = 3'd3,
        RSP_LA = 3'd4
    } state_t;

    localparam logic REQ_WB = 1'b0;
    localparam logic REQ_LA = 1'b1;

    localparam int unsigned DEF_ADDR_W  = 10;
    localparam logic [31:0] DEF_WB_BASE = 32'h3000_0000;

endpackage

// File: rtl/user_mem_arbiter_arb2_rr.sv
// Two-way grant picker: a lone requester always wins; on a tie the fair mode
// grants the requester not served last, otherwise Wishbone wins.
module arb2_rr
    import user_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fair_en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[REQ_WB] && req[REQ_LA]) begin
            if (fair_en && (last_grant == REQ_WB)) begin
                grant[REQ_LA] = 1'b1;
            end else begin
                grant[REQ_WB] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/user_mem_arbiter.sv
// Shares one single-port SRAM between the Caravel Wishbone slave and an LA requester.
// Define MEM_ARB_FAIR_EN for round-robin tie-breaking; otherwise Wishbone has fixed priority.
module user_mem_arbiter
    import user_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = 32,
    parameter logic [31:0] WB_BASE = DEF_WB_BASE
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    input  logic              la_req_i,
    input  logic              la_we_i,
    input  logic [ADDR_W-1:0] la_addr_i,
    input  logic [DATA_W-1:0] la_wdata_i,
    output logic              la_done_o,
    output logic [DATA_W-1:0] la_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_wmask_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output state_t            dbg_state_o
);

    // Handshake: a requester (WB in-window cyc&stb, or la_req_i) is a level that must
    // stay asserted until its one-cycle ack/done pulse; it is only sampled in IDLE,
    // and a level still high in the cycle that shows the pulse counts as a new request.

    state_t      state;
    logic        wb_req;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic        last_grant;
    logic        fair_en;
    logic        unused_adr_bits;

    assign wb_req = wbs_cyc_i && wbs_stb_i &&
                    (wbs_adr_i[31:ADDR_W+2] == WB_BASE[31:ADDR_W+2]);
    assign req[REQ_WB]     = wb_req;
    assign req[REQ_LA]     = la_req_i;
    assign unused_adr_bits = ^wbs_adr_i[1:0];
    assign dbg_state_o     = state;

`ifdef MEM_ARB_FAIR_EN
    assign fair_en = 1'b1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            last_grant <= REQ_LA;
        end else if ((state == IDLE) && (grant != 2'b00)) begin
            last_grant <= grant[REQ_LA] ? REQ_LA : REQ_WB;
        end
    end
`else
    assign fair_en    = 1'b0;
    assign last_grant = REQ_LA;
`endif

    arb2_rr u_arb (
        .req        (req),
        .last_grant (last_grant),
        .fair_en    (fair_en),
        .grant      (grant)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            la_done_o   <= 1'b0;
            la_rdata_o  <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_wmask_o <= 4'h0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            la_done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant[REQ_WB]) begin
                        state       <= ACC_WB;
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= wbs_we_i;
                        mem_wmask_o <= wbs_we_i ? wbs_sel_i : 4'h0;
                        mem_addr_o  <= wbs_adr_i[ADDR_W+1:2];
                        mem_wdata_o <= wbs_dat_i;
                    end else if (grant[REQ_LA]) begin
                        state       <= ACC_LA;
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= la_we_i;
                        mem_wmask_o <= la_we_i ? 4'hF : 4'h0;
                        mem_addr_o  <= la_addr_i;
                        mem_wdata_o <= la_wdata_i;
                    end
                end
                ACC_WB: begin
                    state    <= RSP_WB;
                    mem_en_o <= 1'b0;
                end
                ACC_LA: begin
                    state    <= RSP_LA;
                    mem_en_o <= 1'b0;
                end
                // mem_we_o is held through the access so RSP knows whether to capture.
                RSP_WB: begin
                    state     <= IDLE;
                    wbs_ack_o <= 1'b1;
                    if (!mem_we_o) wbs_dat_o <= mem_rdata_i;
                end
                RSP_LA: begin
                    state     <= IDLE;
                    la_done_o <= 1'b1;
                    if (!mem_we_o) la_rdata_o <= mem_rdata_i;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_user_mem_arbiter.sv
// Directed bench for user_mem_arbiter with a behavioural SRAM and a queue-based scoreboard.
module tb_user_mem_arbiter;
    import user_mem_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_adr, wbs_dat_w;
    logic        wbs_ack;
    logic [31:0] wbs_dat_r;
    logic        la_req, la_we;
    logic [9:0]  la_addr;
    logic [31:0] la_wdata;
    logic        la_done;
    logic [31:0] la_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_wmask;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    state_t      dbg_state;

    user_mem_arbiter dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_cyc_i   (wbs_cyc),
        .wbs_stb_i   (wbs_stb),
        .wbs_we_i    (wbs_we),
        .wbs_sel_i   (wbs_sel),
        .wbs_adr_i   (wbs_adr),
        .wbs_dat_i   (wbs_dat_w),
        .wbs_ack_o   (wbs_ack),
        .wbs_dat_o   (wbs_dat_r),
        .la_req_i    (la_req),
        .la_we_i     (la_we),
        .la_addr_i   (la_addr),
        .la_wdata_i  (la_wdata),
        .la_done_o   (la_done),
        .la_rdata_o  (la_rdata),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_wmask_o (mem_wmask),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // Behavioural SRAM: registered read, byte-masked write.
    logic [31:0] sram [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= sram[mem_addr];
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        we;
        logic [3:0]  wmask;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct packed {
        logic        is_la;
        logic [31:0] wb_dat;
        logic [31:0] la_dat;
    } rsp_t;

    acc_t        exp_acc_q[$];
    rsp_t        exp_rsp_q[$];
    logic [31:0] model_mem [1024];
    logic [31:0] cur_wb_dat = '0;
    logic [31:0] cur_la_dat = '0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Push the expected SRAM access and response for one granted transaction.
    task automatic expect_op(input logic is_la, input logic we, input logic [3:0] sel,
                             input logic [9:0] addr, input logic [31:0] wdata);
        acc_t       a;
        rsp_t       r;
        logic [3:0] m;
        m       = is_la ? 4'hF : sel;
        a.we    = we;
        a.wmask = we ? m : 4'h0;
        a.addr  = addr;
        a.wdata = wdata;
        exp_acc_q.push_back(a);
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (m[b]) model_mem[addr][8*b +: 8] = wdata[8*b +: 8];
        end else if (is_la) begin
            cur_la_dat = model_mem[addr];
        end else begin
            cur_wb_dat = model_mem[addr];
        end
        r.is_la  = is_la;
        r.wb_dat = cur_wb_dat;
        r.la_dat = cur_la_dat;
        exp_rsp_q.push_back(r);
    endtask

    task automatic exp_wb(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat);
        expect_op(1'b0, we, sel, adr[11:2], dat);
    endtask

    task automatic exp_la(input logic we, input logic [9:0] addr, input logic [31:0] dat);
        expect_op(1'b1, we, 4'hF, addr, dat);
    endtask

    // Monitor: compares every SRAM access and every ack/done against the queues.
    initial begin
        acc_t a;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_en) begin
                    if (exp_acc_q.size() == 0) begin
                        check("acc_unexpected", 32'd1, 32'd0);
                    end else begin
                        a = exp_acc_q.pop_front();
                        check("acc_addr", 32'(mem_addr), 32'(a.addr));
                        check("acc_we", 32'(mem_we), 32'(a.we));
                        check("acc_wmask", 32'(mem_wmask), 32'(a.wmask));
                        if (a.we) check("acc_wdata", mem_wdata, a.wdata);
                    end
                end
                if (wbs_ack || la_done) begin
                    if (exp_rsp_q.size() == 0) begin
                        check("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        r = exp_rsp_q.pop_front();
                        check("rsp_src_la", 32'(la_done), 32'(r.is_la));
                        check("rsp_src_wb", 32'(wbs_ack), 32'(!r.is_la));
                        check("rsp_wbs_dat", wbs_dat_r, r.wb_dat);
                        check("rsp_la_rdata", la_rdata, r.la_dat);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wb_op(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output int lat);
        int req_cyc;
        bit seen;
        wbs_cyc   = 1'b1;
        wbs_stb   = 1'b1;
        wbs_we    = we;
        wbs_adr   = adr;
        wbs_sel   = sel;
        wbs_dat_w = dat;
        req_cyc   = cyc_cnt + 1;
        seen      = 1'b0;
        lat       = -1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (wbs_ack) begin
                seen = 1'b1;
                lat  = cyc_cnt - req_cyc;
            end
        end
        if (!seen) check("wb_ack_timeout", 32'd1, 32'd0);
    endtask

    task automatic wb_idle();
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        wbs_we  = 1'b0;
    endtask

    task automatic la_op(input logic we, input logic [9:0] addr, input logic [31:0] dat,
                         output int lat);
        int req_cyc;
        bit seen;
        la_req   = 1'b1;
        la_we    = we;
        la_addr  = addr;
        la_wdata = dat;
        req_cyc  = cyc_cnt + 1;
        seen     = 1'b0;
        lat      = -1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (la_done) begin
                seen = 1'b1;
                lat  = cyc_cnt - req_cyc;
            end
        end
        if (!seen) check("la_done_timeout", 32'd1, 32'd0);
    endtask

    task automatic la_idle();
        la_req = 1'b0;
        la_we  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cur_wb_dat = '0;
        cur_la_dat = '0;
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_wbs_ack"}, 32'(wbs_ack), 32'd0);
        check({tag, "_wbs_dat"}, wbs_dat_r, 32'd0);
        check({tag, "_la_done"}, 32'(la_done), 32'd0);
        check({tag, "_la_rdata"}, la_rdata, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int n_ack, n_en;
        rst_n = 1'b0;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0; wbs_sel = 4'h0;
        wbs_adr = '0; wbs_dat_w = '0;
        la_req = 1'b0; la_we = 1'b0; la_addr = '0; la_wdata = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // 1: full-word write then read-back, checking latency.
        @(posedge clk); #1;
        exp_wb(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF);
        wb_op(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, lat);
        wb_idle();
        check("t1_write_latency", 32'(lat), 32'd2);
        @(posedge clk); #1;
        exp_wb(1'b0, 32'h3000_0010, 4'hF, 32'h0);
        wb_op(1'b0, 32'h3000_0010, 4'hF, 32'h0, lat);
        wb_idle();
        check("t1_read_latency", 32'(lat), 32'd2);
        check("t1_read_data", wbs_dat_r, 32'hDEAD_BEEF);

        // 2: byte-masked write over 0x1111_1111.
        @(posedge clk); #1;
        exp_wb(1'b1, 32'h3000_0020, 4'hF, 32'h1111_1111);
        wb_op(1'b1, 32'h3000_0020, 4'hF, 32'h1111_1111, lat);
        exp_wb(1'b1, 32'h3000_0020, 4'b0010, 32'h0000_AB00);
        wb_op(1'b1, 32'h3000_0020, 4'b0010, 32'h0000_AB00, lat);
        exp_wb(1'b0, 32'h3000_0020, 4'hF, 32'h0);
        wb_op(1'b0, 32'h3000_0020, 4'hF, 32'h0, lat);
        wb_idle();
        check("t2_masked_readback", wbs_dat_r, 32'h1111_AB11);

        // 3: out-of-window strobe is never served.
        @(posedge clk); #1;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_sel = 4'hF;
        wbs_adr = 32'h3100_0000; wbs_dat_w = 32'h0BAD_0BAD;
        n_ack = 0; n_en = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wbs_ack) n_ack++;
            if (mem_en) n_en++;
        end
        wb_idle();
        check("t3_oow_acks", 32'(n_ack), 32'd0);
        check("t3_oow_mem_en", 32'(n_en), 32'd0);

        // 5: LA read of word 4; WB read data must stay put.
        @(posedge clk); #1;
        exp_la(1'b0, 10'd4, 32'h0);
        la_op(1'b0, 10'd4, 32'h0, lat);
        la_idle();
        check("t5_la_latency", 32'(lat), 32'd2);
        check("t5_la_rdata", la_rdata, 32'hDEAD_BEEF);
        check("t5_wbs_dat_kept", wbs_dat_r, 32'h1111_AB11);

        // 6: reset in ACC_WB drops the transaction.
        @(posedge clk); #1;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_sel = 4'hF;
        wbs_adr = 32'h3000_0040; wbs_dat_w = 32'h5555_AAAA;
        @(posedge clk); #2;
        check("t6_in_acc_wb", 32'(dbg_state), 32'(ACC_WB));
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        wb_idle();
        repeat (2) @(negedge clk);
        cur_wb_dat = '0;
        cur_la_dat = '0;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_no_late_ack", 32'(exp_rsp_q.size()), 32'd0);
        @(posedge clk); #1;
        exp_wb(1'b0, 32'h3000_0010, 4'hF, 32'h0);
        wb_op(1'b0, 32'h3000_0010, 4'hF, 32'h0, lat);
        wb_idle();
        check("t6_after_reset_latency", 32'(lat), 32'd2);
        check("t6_after_reset_data", wbs_dat_r, 32'hDEAD_BEEF);

        // 4: both requesters continuously active from a fresh reset.
        do_reset();
        @(posedge clk); #1;
`ifdef MEM_ARB_FAIR_EN
        exp_wb(1'b1, 32'h3000_0080, 4'hF, 32'hA0A0_0000);
        exp_la(1'b0, 10'd4, 32'h0);
        exp_wb(1'b1, 32'h3000_0084, 4'hF, 32'hB1B2_0000);
        exp_la(1'b1, 10'd40, 32'hCAFE_0001);
        exp_wb(1'b0, 32'h3000_0080, 4'hF, 32'h0);
        exp_wb(1'b0, 32'h3000_0084, 4'hF, 32'h0);
`else
        exp_wb(1'b1, 32'h3000_0080, 4'hF, 32'hA0A0_0000);
        exp_wb(1'b1, 32'h3000_0084, 4'hF, 32'hB1B2_0000);
        exp_wb(1'b0, 32'h3000_0080, 4'hF, 32'h0);
        exp_wb(1'b0, 32'h3000_0084, 4'hF, 32'h0);
        exp_la(1'b0, 10'd4, 32'h0);
        exp_la(1'b1, 10'd40, 32'hCAFE_0001);
`endif
        fork
            begin
                int wl;
                wb_op(1'b1, 32'h3000_0080, 4'hF, 32'hA0A0_0000, wl);
                wb_op(1'b1, 32'h3000_0084, 4'hF, 32'hB1B2_0000, wl);
                wb_op(1'b0, 32'h3000_0080, 4'hF, 32'h0, wl);
                wb_op(1'b0, 32'h3000_0084, 4'hF, 32'h0, wl);
                wb_idle();
            end
            begin
                int ll;
                la_op(1'b0, 10'd4, 32'h0, ll);
                la_op(1'b1, 10'd40, 32'hCAFE_0001, ll);
                la_idle();
            end
        join
        repeat (4) @(negedge clk);
        check("t4_wbs_dat_final", wbs_dat_r, 32'hB1B2_0000);
        check("t4_la_rdata_final", la_rdata, 32'hDEAD_BEEF);
        check("t4_la_write_stored", sram[40], 32'hCAFE_0001);

        check("end_acc_q_empty", 32'(exp_acc_q.size()), 32'd0);
        check("end_rsp_q_empty", 32'(exp_rsp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
